// File: rtl/exp7_unidade_controle_if.sv
// Handshake bundle between the memory-game control unit and its datapath.
// master: control unit (reads datapath status, drives datapath controls and game flags)
// slave : datapath side (drives status, reads controls)
// Status : iniciar, jogada_feita, jogada_correta, enderecoIgualRodada, fimCR, meioCR,
//          fimTM, meioTM, fimTempo, meioTempo, nivel_jogadas_reg, nivel_tempo_reg, modo2_reg
// Control: zeraR, registraN, zeraC, contaC, zeraCR, contaCR, zeraTM, contaTM, zeraTempo,
//          contaTempo, registraR, gravaM, ativa_leds_mem, ativa_leds_jog, toca
// Flags  : pronto, ganhou, perdeu, timeout, db_estado[4:0]
interface exp7_unidade_controle_if;
  localparam int unsigned STATE_W = 5;

  logic iniciar;
  logic jogada_feita;
  logic jogada_correta;
  logic enderecoIgualRodada;
  logic fimCR;
  logic meioCR;
  logic fimTM;
  logic meioTM;
  logic fimTempo;
  logic meioTempo;
  logic nivel_jogadas_reg;
  logic nivel_tempo_reg;
  logic modo2_reg;

  logic zeraR;
  logic registraN;
  logic zeraC;
  logic contaC;
  logic zeraCR;
  logic contaCR;
  logic zeraTM;
  logic contaTM;
  logic zeraTempo;
  logic contaTempo;
  logic registraR;
  logic gravaM;
  logic ativa_leds_mem;
  logic ativa_leds_jog;
  logic toca;

  logic pronto;
  logic ganhou;
  logic perdeu;
  logic timeout;
  logic [STATE_W-1:0] db_estado;

  modport master (
    input  iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
           fimCR, meioCR, fimTM, meioTM, fimTempo, meioTempo,
           nivel_jogadas_reg, nivel_tempo_reg, modo2_reg,
    output zeraR, registraN, zeraC, contaC, zeraCR, contaCR, zeraTM, contaTM,
           zeraTempo, contaTempo, registraR, gravaM, ativa_leds_mem,
           ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout, db_estado
  );

  modport slave (
    output iniciar, jogada_feita, jogada_correta, enderecoIgualRodada,
           fimCR, meioCR, fimTM, meioTM, fimTempo, meioTempo,
           nivel_jogadas_reg, nivel_tempo_reg, modo2_reg,
    input  zeraR, registraN, zeraC, contaC, zeraCR, contaCR, zeraTM, contaTM,
           zeraTempo, contaTempo, registraR, gravaM, ativa_leds_mem,
           ativa_leds_jog, toca, pronto, ganhou, perdeu, timeout, db_estado
  );
endinterface

// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the memory game: captures settings, plays back the stored
// sequence up to the current round, checks each press (with timeout), optionally
// appends a new press per round (mode 2), and reports win / loss / timeout.
// Ports: clock, reset (synchronous, active-high), bus (exp7_unidade_controle_if.master).
// Outputs are registered from the next-state decode, so they always match db_estado.
module exp7_unidade_controle (
  input  logic                          clock,
  input  logic                          reset,
  exp7_unidade_controle_if.master       bus
);
  localparam int unsigned STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    INICIAL     = 5'h00,
    PREPARA     = 5'h01,
    REG_NIVEL   = 5'h02,
    NOVA_RODADA = 5'h03,
    MOSTRA      = 5'h04,
    APAGA       = 5'h05,
    PROX_MOSTRA = 5'h06,
    FIM_MOSTRA  = 5'h07,
    ESPERA      = 5'h08,
    REGISTRA    = 5'h09,
    COMPARA     = 5'h0A,
    PROX_JOGADA = 5'h0B,
    PREP_NOVA   = 5'h0C,
    ESPERA_NOVA = 5'h0D,
    GRAVA       = 5'h0E,
    PROX_RODADA = 5'h10,
    ERRO        = 5'h11,
    TIMEOUT_S   = 5'h12,
    ACERTOU     = 5'h13
  } state_t;

  typedef struct packed {
    logic zeraR;
    logic registraN;
    logic zeraC;
    logic contaC;
    logic zeraCR;
    logic contaCR;
    logic zeraTM;
    logic contaTM;
    logic zeraTempo;
    logic contaTempo;
    logic registraR;
    logic gravaM;
    logic ativa_leds_mem;
    logic ativa_leds_jog;
    logic toca;
    logic pronto;
    logic ganhou;
    logic perdeu;
    logic timeout;
  } ctrl_t;

  state_t state;
  state_t state_next;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_next;

  logic fim_rodadas;
  logic estourou;

  // Last round depends on game length; timeout on the selected time level.
  assign fim_rodadas = bus.nivel_jogadas_reg ? bus.fimCR : bus.meioCR;
  assign estourou    = bus.nivel_tempo_reg ? bus.meioTempo : bus.fimTempo;

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= INICIAL;
      ctrl_q <= '0;
    end else begin
      state  <= state_next;
      ctrl_q <= ctrl_next;
    end
  end

  // Next-state logic and Moore decode of the upcoming state.
  always_comb begin
    state_next = state;
    ctrl_next  = '0;

    case (state)
      INICIAL:     if (bus.iniciar) state_next = PREPARA;
      PREPARA:     state_next = REG_NIVEL;
      REG_NIVEL:   state_next = NOVA_RODADA;
      NOVA_RODADA: state_next = MOSTRA;
      MOSTRA:      if (bus.meioTM) state_next = APAGA;
      APAGA: begin
        if (bus.fimTM) state_next = bus.enderecoIgualRodada ? FIM_MOSTRA : PROX_MOSTRA;
      end
      PROX_MOSTRA: state_next = MOSTRA;
      FIM_MOSTRA:  state_next = ESPERA;
      // A press in the same cycle as the timeout still counts.
      ESPERA: begin
        if (bus.jogada_feita) state_next = REGISTRA;
        else if (estourou)    state_next = TIMEOUT_S;
      end
      REGISTRA:    state_next = COMPARA;
      COMPARA: begin
        if (!bus.jogada_correta)           state_next = ERRO;
        else if (!bus.enderecoIgualRodada) state_next = PROX_JOGADA;
        else if (fim_rodadas)              state_next = ACERTOU;
        else if (bus.modo2_reg)            state_next = PREP_NOVA;
        else                               state_next = PROX_RODADA;
      end
      PROX_JOGADA: state_next = ESPERA;
      PREP_NOVA:   state_next = ESPERA_NOVA;
      ESPERA_NOVA: begin
        if (bus.jogada_feita) state_next = GRAVA;
        else if (estourou)    state_next = TIMEOUT_S;
      end
      GRAVA:       state_next = PROX_RODADA;
      PROX_RODADA: state_next = NOVA_RODADA;
      ERRO, TIMEOUT_S, ACERTOU: if (bus.iniciar) state_next = PREPARA;
      default:     state_next = INICIAL;
    endcase

    case (state_next)
      PREPARA: begin
        ctrl_next.zeraR     = 1'b1;
        ctrl_next.zeraC     = 1'b1;
        ctrl_next.zeraCR    = 1'b1;
        ctrl_next.zeraTM    = 1'b1;
        ctrl_next.zeraTempo = 1'b1;
      end
      REG_NIVEL:   ctrl_next.registraN = 1'b1;
      NOVA_RODADA: begin
        ctrl_next.zeraC  = 1'b1;
        ctrl_next.zeraTM = 1'b1;
      end
      MOSTRA: begin
        ctrl_next.ativa_leds_mem = 1'b1;
        ctrl_next.toca           = 1'b1;
        ctrl_next.contaTM        = 1'b1;
      end
      APAGA:       ctrl_next.contaTM = 1'b1;
      PROX_MOSTRA: begin
        ctrl_next.contaC = 1'b1;
        ctrl_next.zeraTM = 1'b1;
      end
      FIM_MOSTRA: begin
        ctrl_next.zeraC     = 1'b1;
        ctrl_next.zeraTempo = 1'b1;
      end
      ESPERA:      ctrl_next.contaTempo = 1'b1;
      REGISTRA:    ctrl_next.registraR  = 1'b1;
      COMPARA: begin
        ctrl_next.ativa_leds_jog = 1'b1;
        ctrl_next.toca           = 1'b1;
      end
      PROX_JOGADA, PREP_NOVA: begin
        ctrl_next.contaC    = 1'b1;
        ctrl_next.zeraTempo = 1'b1;
      end
      ESPERA_NOVA: ctrl_next.contaTempo = 1'b1;
      GRAVA: begin
        ctrl_next.gravaM    = 1'b1;
        ctrl_next.registraR = 1'b1;
      end
      PROX_RODADA: ctrl_next.contaCR = 1'b1;
      ERRO: begin
        ctrl_next.pronto = 1'b1;
        ctrl_next.perdeu = 1'b1;
      end
      TIMEOUT_S: begin
        ctrl_next.pronto  = 1'b1;
        ctrl_next.perdeu  = 1'b1;
        ctrl_next.timeout = 1'b1;
      end
      ACERTOU: begin
        ctrl_next.pronto = 1'b1;
        ctrl_next.ganhou = 1'b1;
      end
      default: ctrl_next = '0;
    endcase
  end

  assign bus.zeraR          = ctrl_q.zeraR;
  assign bus.registraN      = ctrl_q.registraN;
  assign bus.zeraC          = ctrl_q.zeraC;
  assign bus.contaC         = ctrl_q.contaC;
  assign bus.zeraCR         = ctrl_q.zeraCR;
  assign bus.contaCR        = ctrl_q.contaCR;
  assign bus.zeraTM         = ctrl_q.zeraTM;
  assign bus.contaTM        = ctrl_q.contaTM;
  assign bus.zeraTempo      = ctrl_q.zeraTempo;
  assign bus.contaTempo     = ctrl_q.contaTempo;
  assign bus.registraR      = ctrl_q.registraR;
  assign bus.gravaM         = ctrl_q.gravaM;
  assign bus.ativa_leds_mem = ctrl_q.ativa_leds_mem;
  assign bus.ativa_leds_jog = ctrl_q.ativa_leds_jog;
  assign bus.toca           = ctrl_q.toca;
  assign bus.pronto         = ctrl_q.pronto;
  assign bus.ganhou         = ctrl_q.ganhou;
  assign bus.perdeu         = ctrl_q.perdeu;
  assign bus.timeout        = ctrl_q.timeout;
  assign bus.db_estado      = state;
endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Directed self-checking bench for exp7_unidade_controle: drives datapath status by hand
// and checks state codes and control outputs against hand-derived values.
module tb_exp7_unidade_controle;
  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cr_pulses;
  int   grava_cycles;

  exp7_unidade_controle_if bus ();

  exp7_unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the posedge, outputs sampled on the following negedge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    if (bus.contaCR) cr_pulses++;
    if (bus.gravaM)  grava_cycles++;
  endtask

  function automatic logic [18:0] all_outs();
    return {bus.zeraR, bus.registraN, bus.zeraC, bus.contaC, bus.zeraCR, bus.contaCR,
            bus.zeraTM, bus.contaTM, bus.zeraTempo, bus.contaTempo, bus.registraR,
            bus.gravaM, bus.ativa_leds_mem, bus.ativa_leds_jog, bus.toca,
            bus.pronto, bus.ganhou, bus.perdeu, bus.timeout};
  endfunction

  task automatic clear_inputs();
    bus.iniciar = 0; bus.jogada_feita = 0; bus.jogada_correta = 0;
    bus.enderecoIgualRodada = 0; bus.fimCR = 0; bus.meioCR = 0;
    bus.fimTM = 0; bus.meioTM = 0; bus.fimTempo = 0; bus.meioTempo = 0;
  endtask

  // From INICIAL or an end state: iniciar, then 01,02,03,04.
  task automatic start_game();
    bus.iniciar = 1;
    tick();
    bus.iniciar = 0;
    chk("start_01", 32'(bus.db_estado), 32'h01);
    tick();
    chk("start_02", 32'(bus.db_estado), 32'h02);
    tick();
    chk("start_03", 32'(bus.db_estado), 32'h03);
    tick();
    chk("start_04", 32'(bus.db_estado), 32'h04);
  endtask

  // Playback of words 0..r, ending in ESPERA.
  task automatic playback(input int r);
    for (int k = 0; k <= r; k++) begin
      chk("pb_mostra", 32'(bus.db_estado), 32'h04);
      chk("pb_leds", 32'(bus.ativa_leds_mem), 32'h1);
      bus.meioTM = 1;
      tick();
      bus.meioTM = 0;
      chk("pb_apaga", 32'(bus.db_estado), 32'h05);
      bus.fimTM = 1;
      bus.enderecoIgualRodada = (k == r);
      tick();
      bus.fimTM = 0;
      bus.enderecoIgualRodada = 0;
      if (k < r) begin
        chk("pb_prox", 32'(bus.db_estado), 32'h06);
        tick();
      end
    end
    chk("pb_fim", 32'(bus.db_estado), 32'h07);
    tick();
    chk("pb_espera", 32'(bus.db_estado), 32'h08);
  endtask

  // One press from ESPERA through COMPARA; leaves the FSM in the state after COMPARA.
  task automatic press(input bit correct, input bit last, input bit meio, input bit fim);
    bus.jogada_feita = 1;
    tick();
    bus.jogada_feita = 0;
    chk("pr_registra", 32'(bus.db_estado), 32'h09);
    tick();
    chk("pr_compara", 32'(bus.db_estado), 32'h0A);
    chk("pr_leds_jog", 32'(bus.ativa_leds_jog), 32'h1);
    bus.jogada_correta = correct;
    bus.enderecoIgualRodada = last;
    bus.meioCR = meio;
    bus.fimCR = fim;
    tick();
    clear_inputs();
  endtask

  initial begin
    checks = 0; errors = 0; cr_pulses = 0; grava_cycles = 0;
    clear_inputs();
    bus.nivel_jogadas_reg = 0; bus.nivel_tempo_reg = 0; bus.modo2_reg = 0;
    reset = 1;
    tick();
    tick();
    chk("rst_state", 32'(bus.db_estado), 32'h00);
    chk("rst_outs", 32'(all_outs()), 32'h0);
    reset = 0;
    tick();
    chk("idle_hold", 32'(bus.db_estado), 32'h00);

    // Full 8-round game in short mode, every press correct.
    start_game();
    chk("prep_zeros", 32'({bus.zeraR, bus.zeraC, bus.zeraCR, bus.zeraTM, bus.zeraTempo}), 32'h0);
    for (int r = 0; r < 8; r++) begin
      playback(r);
      for (int k = 0; k <= r; k++) begin
        press(1'b1, k == r, r == 7, 1'b0);
        if (k < r) begin
          chk("win_prox_jog", 32'(bus.db_estado), 32'h0B);
          tick();
          chk("win_espera", 32'(bus.db_estado), 32'h08);
        end
      end
      if (r < 7) begin
        chk("win_prox_rod", 32'(bus.db_estado), 32'h10);
        tick();
        chk("win_nova", 32'(bus.db_estado), 32'h03);
        tick();
      end
    end
    chk("win_state", 32'(bus.db_estado), 32'h13);
    chk("win_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'hC);
    chk("win_contaCR", 32'(cr_pulses), 32'd7);
    tick();
    chk("win_hold", 32'(bus.db_estado), 32'h13);

    // Loss: rounds 0,1 correct; second press of round 2 wrong.
    start_game();
    for (int r = 0; r < 3; r++) begin
      playback(r);
      for (int k = 0; k <= r; k++) begin
        if (r == 2 && k == 1) begin
          press(1'b0, 1'b0, 1'b0, 1'b0);
          break;
        end
        press(1'b1, k == r, 1'b0, 1'b0);
        if (k < r) tick();
      end
      if (r < 2) begin
        chk("loss_prox_rod", 32'(bus.db_estado), 32'h10);
        tick();
        tick();
      end
    end
    chk("loss_state", 32'(bus.db_estado), 32'h11);
    chk("loss_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'hA);
    bus.jogada_feita = 1;
    tick();
    bus.jogada_feita = 0;
    chk("loss_ignore_press", 32'(bus.db_estado), 32'h11);

    // Timeout with short time level: meioTempo ends the wait.
    bus.nivel_tempo_reg = 1;
    start_game();
    playback(0);
    tick();
    chk("to1_wait", 32'(bus.db_estado), 32'h08);
    chk("to1_contaTempo", 32'(bus.contaTempo), 32'h1);
    bus.meioTempo = 1;
    tick();
    bus.meioTempo = 0;
    chk("to1_state", 32'(bus.db_estado), 32'h12);
    chk("to1_flags", 32'({bus.pronto, bus.ganhou, bus.perdeu, bus.timeout}), 32'hB);

    // Timeout with long time level: meioTempo ignored, fimTempo ends the wait.
    bus.nivel_tempo_reg = 0;
    start_game();
    playback(0);
    bus.meioTempo = 1;
    tick();
    bus.meioTempo = 0;
    chk("to0_meio", 32'(bus.db_estado), 32'h08);
    bus.fimTempo = 1;
    tick();
    bus.fimTempo = 0;
    chk("to0_fim", 32'(bus.db_estado), 32'h12);

    // Press and timeout together: the press wins.
    start_game();
    playback(0);
    bus.jogada_feita = 1;
    bus.fimTempo = 1;
    tick();
    clear_inputs();
    chk("prio_state", 32'(bus.db_estado), 32'h09);
    chk("prio_registraR", 32'(bus.registraR), 32'h1);

    // Long game: meioCR alone is not the final round.
    bus.nivel_jogadas_reg = 1;
    tick();
    bus.jogada_correta = 1; bus.enderecoIgualRodada = 1; bus.meioCR = 1;
    tick();
    clear_inputs();
    chk("long_meio", 32'(bus.db_estado), 32'h10);
    tick();
    tick();
    playback(1);

    // Reset mid-game from ESPERA.
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_state", 32'(bus.db_estado), 32'h00);
    chk("mid_rst_outs", 32'(all_outs()), 32'h0);
    bus.nivel_jogadas_reg = 0;

    // Mode 2: round 0 correct, then a new press is recorded.
    bus.modo2_reg = 1;
    start_game();
    playback(0);
    grava_cycles = 0;
    press(1'b1, 1'b1, 1'b0, 1'b0);
    chk("m2_prep", 32'(bus.db_estado), 32'h0C);
    chk("m2_prep_ctl", 32'({bus.contaC, bus.zeraTempo}), 32'h3);
    tick();
    chk("m2_espera", 32'(bus.db_estado), 32'h0D);
    chk("m2_contaTempo", 32'(bus.contaTempo), 32'h1);
    bus.jogada_feita = 1;
    tick();
    bus.jogada_feita = 0;
    chk("m2_grava", 32'(bus.db_estado), 32'h0E);
    chk("m2_grava_ctl", 32'({bus.gravaM, bus.registraR}), 32'h3);
    tick();
    chk("m2_prox_rod", 32'(bus.db_estado), 32'h10);
    chk("m2_gravaM_off", 32'(bus.gravaM), 32'h0);
    tick();
    chk("m2_nova", 32'(bus.db_estado), 32'h03);
    chk("m2_grava_once", 32'(grava_cycles), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
